// File: rtl/histo_pkg.sv
// Shared definitions for the greyscale histogram engine: phase encodings and default sizes.
package histo_pkg;

    localparam int unsigned BINS_DEF       = 256;
    localparam int unsigned BIN_W_DEF      = 8;
    localparam int unsigned CNT_W_DEF      = 20;
    localparam int unsigned SETTLE_CYC_DEF = 4;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_ACCUM  = 3'd1,
        PH_SETTLE = 3'd2,
        PH_COPY   = 3'd3,
        PH_CLEAR  = 3'd4,
        PH_DONE   = 3'd5
    } phase_e;

endpackage

// File: rtl/histo_cum_thresh.sv
// Running cumulative bin sum with first-crossing threshold capture.
// Build option HISTO_SEQ_CUM_SAT_EN: saturate the sum instead of wrapping.
module histo_cum_thresh
    import histo_pkg::*;
#(
    parameter int unsigned BIN_W = BIN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [BIN_W-1:0] idx,
    input  logic [CNT_W-1:0] bin,
    input  logic [CNT_W-1:0] level,
    output logic [CNT_W-1:0] cum_c,
    output logic             crossed,
    output logic [BIN_W-1:0] cross_bin
);

    logic [CNT_W-1:0] cum_q;

`ifdef HISTO_SEQ_CUM_SAT_EN
    logic [CNT_W:0] sum_c;

    always_comb begin
        sum_c = {1'b0, cum_q} + {1'b0, bin};
        cum_c = sum_c[CNT_W] ? {CNT_W{1'b1}} : sum_c[CNT_W-1:0];
    end
`else
    always_comb begin
        cum_c = cum_q + bin;
    end
`endif

    // Only the first bin whose new sum strictly exceeds the level is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cum_q     <= '0;
            crossed   <= 1'b0;
            cross_bin <= '0;
        end else if (clr) begin
            cum_q     <= '0;
            crossed   <= 1'b0;
            cross_bin <= '0;
        end else if (en) begin
            cum_q <= cum_c;
            if (!crossed && (cum_c > level)) begin
                crossed   <= 1'b1;
                cross_bin <= idx;
            end
        end
    end

endmodule

// File: rtl/histo_frame_sequencer.sv
// Per-frame phase controller: accumulate, settle, copy temp bins to display/cum RAMs, clear.
// Build option HISTO_SEQ_CUM_SAT_EN (in histo_cum_thresh): saturating cumulative sum.
module histo_frame_sequencer
    import histo_pkg::*;
#(
    parameter int unsigned BINS       = BINS_DEF,
    parameter int unsigned BIN_W      = BIN_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             iPclk,
    input  logic             iRST_N,
    input  logic             iFval,
    input  logic [CNT_W-1:0] iThresh_Level,
    input  logic             iFreeze,
    input  logic [CNT_W-1:0] iTmp_Q,
    output logic             oAccum_En,
    output logic [BIN_W-1:0] oTmp_Rd_Addr,
    output logic [BIN_W-1:0] oTmp_Wr_Addr,
    output logic             oTmp_Clr_Wen,
    output logic [BIN_W-1:0] oCopy_Addr,
    output logic [CNT_W-1:0] oDisp_D,
    output logic [CNT_W-1:0] oCum_D,
    output logic             oCopy_Wen,
    output logic [2:0]       oPhase,
    output logic [BIN_W-1:0] oThresh_Bin,
    output logic             oThresh_Valid,
    output logic             oFrame_Done,
    output logic             oSkip
);

    localparam int unsigned CW          = BIN_W + 1;
    localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LAST_COPY   = CW'(BINS);
    localparam logic [CW-1:0] LAST_CLEAR  = CW'(BINS - 1);

    phase_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             boot_q;
    logic             fval_q;
    logic             rise_c;
    logic             busy_c;
    logic             cum_clr_c;
    logic             cum_en_c;
    logic [BIN_W-1:0] cum_idx_c;
    logic [CNT_W-1:0] cum_c;
    logic             crossed;
    logic [BIN_W-1:0] cross_bin;

    assign rise_c       = iFval & ~fval_q;
    assign busy_c       = (state_q == PH_SETTLE) || (state_q == PH_COPY) ||
                          (state_q == PH_CLEAR)  || (state_q == PH_DONE);
    assign cum_clr_c    = (state_q == PH_SETTLE);
    assign cum_en_c     = (state_q == PH_COPY) && (cnt_q != '0);
    assign cum_idx_c    = BIN_W'(cnt_q - CW'(1));
    assign oTmp_Rd_Addr = BIN_W'(cnt_q);
    assign oPhase       = state_q;

    histo_cum_thresh #(
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_cum_thresh (
        .clk       (iPclk),
        .rst_n     (iRST_N),
        .clr       (cum_clr_c),
        .en        (cum_en_c),
        .idx       (cum_idx_c),
        .bin       (iTmp_Q),
        .level     (iThresh_Level),
        .cum_c     (cum_c),
        .crossed   (crossed),
        .cross_bin (cross_bin)
    );

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= PH_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Phase sequencing; the counter is the bin index in COPY/CLEAR and the delay in SETTLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            PH_IDLE: begin
                cnt_d = '0;
                if (rise_c) state_d = PH_ACCUM;
            end
            PH_ACCUM: begin
                cnt_d = '0;
                if (!iFval) state_d = PH_SETTLE;
            end
            PH_SETTLE: begin
                if (cnt_q == LAST_SETTLE) begin
                    state_d = PH_COPY;
                    cnt_d   = '0;
                end
            end
            PH_COPY: begin
                if (cnt_q == LAST_COPY) begin
                    state_d = PH_CLEAR;
                    cnt_d   = '0;
                end
            end
            PH_CLEAR: begin
                if (cnt_q == LAST_CLEAR) begin
                    state_d = boot_q ? PH_IDLE : PH_DONE;
                    cnt_d   = '0;
                end
            end
            PH_DONE: begin
                state_d = PH_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = PH_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered RAM controls and status; copy/clear writes trail their read/count cycle by one.
    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            fval_q        <= 1'b0;
            boot_q        <= 1'b1;
            oAccum_En     <= 1'b0;
            oTmp_Clr_Wen  <= 1'b0;
            oTmp_Wr_Addr  <= '0;
            oCopy_Wen     <= 1'b0;
            oCopy_Addr    <= '0;
            oDisp_D       <= '0;
            oCum_D        <= '0;
            oFrame_Done   <= 1'b0;
            oSkip         <= 1'b0;
            oThresh_Bin   <= '0;
            oThresh_Valid <= 1'b0;
        end else begin
            fval_q       <= iFval;
            if ((state_q == PH_CLEAR) && (cnt_q == LAST_CLEAR)) boot_q <= 1'b0;
            oAccum_En    <= (state_d == PH_ACCUM) || (state_d == PH_SETTLE);
            oTmp_Clr_Wen <= (state_q == PH_CLEAR);
            oTmp_Wr_Addr <= BIN_W'(cnt_q);
            oCopy_Wen    <= cum_en_c & ~iFreeze;
            if (cum_en_c) begin
                oCopy_Addr <= cum_idx_c;
                oDisp_D    <= iTmp_Q;
                oCum_D     <= cum_c;
            end
            oFrame_Done  <= (state_d == PH_DONE);
            oSkip        <= rise_c & busy_c;
            if ((state_d == PH_DONE) && !iFreeze) begin
                oThresh_Bin   <= crossed ? cross_bin : BIN_W'(BINS - 1);
                oThresh_Valid <= crossed;
            end
        end
    end

endmodule

// File: tb/tb_histo_frame_sequencer.sv
// Directed bench for histo_frame_sequencer with a behavioural temp-bin RAM and write loggers.
module tb_histo_frame_sequencer;

    localparam int unsigned BINS  = 256;
    localparam int unsigned BIN_W = 8;
    localparam int unsigned CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fval;
    logic [CNT_W-1:0] level;
    logic             freeze;
    logic [CNT_W-1:0] tmp_q;
    logic             accum_en;
    logic [BIN_W-1:0] tmp_rd_addr;
    logic [BIN_W-1:0] tmp_wr_addr;
    logic             tmp_clr_wen;
    logic [BIN_W-1:0] copy_addr;
    logic [CNT_W-1:0] disp_d;
    logic [CNT_W-1:0] cum_d;
    logic             copy_wen;
    logic [2:0]       phase;
    logic [BIN_W-1:0] thresh_bin;
    logic             thresh_valid;
    logic             frame_done;
    logic             skip;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    histo_frame_sequencer dut (
        .iPclk         (clk),
        .iRST_N        (rst_n),
        .iFval         (fval),
        .iThresh_Level (level),
        .iFreeze       (freeze),
        .iTmp_Q        (tmp_q),
        .oAccum_En     (accum_en),
        .oTmp_Rd_Addr  (tmp_rd_addr),
        .oTmp_Wr_Addr  (tmp_wr_addr),
        .oTmp_Clr_Wen  (tmp_clr_wen),
        .oCopy_Addr    (copy_addr),
        .oDisp_D       (disp_d),
        .oCum_D        (cum_d),
        .oCopy_Wen     (copy_wen),
        .oPhase        (phase),
        .oThresh_Bin   (thresh_bin),
        .oThresh_Valid (thresh_valid),
        .oFrame_Done   (frame_done),
        .oSkip         (skip)
    );

    // Temp-bin RAM: one-cycle read latency, clear writes from the DUT, bulk preload from the bench.
    logic [CNT_W-1:0] tmp_ram  [BINS];
    logic [CNT_W-1:0] load_img [BINS];
    logic             load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < BINS; i++) tmp_ram[i] <= load_img[i];
        end else if (tmp_clr_wen) begin
            tmp_ram[tmp_wr_addr] <= '0;
        end
        tmp_q <= tmp_ram[tmp_rd_addr];
    end

    // Write/pulse logger; samples the values held during the cycle that just ended.
    int               copy_cnt  = 0;
    int               clr_cnt   = 0;
    int               done_cnt  = 0;
    int               skip_cnt  = 0;
    int               order_err = 0;
    logic [CNT_W-1:0] disp_log [BINS];
    logic [CNT_W-1:0] cum_log  [BINS];

    always @(posedge clk) begin
        if (rst_n) begin
            if (copy_wen) begin
                if (int'(copy_addr) != copy_cnt % BINS) order_err++;
                disp_log[copy_addr] = disp_d;
                cum_log[copy_addr]  = cum_d;
                copy_cnt++;
            end
            if (tmp_clr_wen) begin
                if (int'(tmp_wr_addr) != clr_cnt % BINS) order_err++;
                clr_cnt++;
            end
            if (frame_done) done_cnt++;
            if (skip) skip_cnt++;
        end
    end

    task automatic load_bins(input logic [CNT_W-1:0] v0, input logic [CNT_W-1:0] v1,
                             input logic [CNT_W-1:0] rest);
        for (int i = 0; i < BINS; i++) load_img[i] = rest;
        load_img[0] = v0;
        load_img[1] = v1;
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic wait_done(input int start, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_cnt != start) break;
        end
        vectors++;
        if (done_cnt == start) begin
            errors++;
            $display("FAIL frame_done_timeout: done_cnt=%0d required>%0d", done_cnt, start);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input int hi, input logic [CNT_W-1:0] lvl, input logic frz,
                             output logic accum_seen, output int d_copy, output int d_clr,
                             output int d_done);
        int c0, k0, n0;
        c0 = copy_cnt; k0 = clr_cnt; n0 = done_cnt;
        level = lvl; freeze = frz;
        @(posedge clk); #1 fval = 1'b1;
        repeat (3) @(negedge clk);
        accum_seen = accum_en && (phase == 3'd1);
        repeat (hi) @(posedge clk);
        #1 fval = 1'b0;
        wait_done(n0, 1200);
        d_copy = copy_cnt - c0; d_clr = clr_cnt - k0; d_done = done_cnt - n0;
    endtask

    task automatic test_reset;
        int n;
        rst_n = 1'b0; fval = 1'b0; level = '0; freeze = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (phase !== 3'd4 || thresh_bin !== '0 || thresh_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: phase=%0d bin=%0d valid=%b required 4/0/0",
                     phase, thresh_bin, thresh_valid);
        end
        vectors++;
        if (frame_done !== 1'b0 || copy_wen !== 1'b0 || tmp_clr_wen !== 1'b0 ||
            accum_en !== 1'b0 || skip !== 1'b0) begin
            errors++;
            $display("FAIL reset_enables: done=%b cwen=%b clrwen=%b accum=%b skip=%b required all 0",
                     frame_done, copy_wen, tmp_clr_wen, accum_en, skip);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        n = 0;
        while (phase !== 3'd0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL reset_to_idle: phase=%0d required 0", phase);
        end
        vectors++;
        if (clr_cnt != 256 || order_err != 0) begin
            errors++;
            $display("FAIL reset_clear: writes=%0d order_err=%0d required 256/0", clr_cnt, order_err);
        end
        vectors++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL reset_no_done: done_pulses=%0d required 0", done_cnt);
        end
    endtask

    task automatic test_threshold;
        logic acc; int dc, dk, dd;
        load_bins(20'd10, 20'd10, 20'd10);
        run_frame(1000, 20'd1279, 1'b0, acc, dc, dk, dd);
        vectors++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL accum_enable: seen=%b required 1", acc);
        end
        vectors++;
        if (dc != 256 || dk != 256 || dd != 1 || order_err != 0) begin
            errors++;
            $display("FAIL thr_counts: copy=%0d clr=%0d done=%0d order=%0d required 256/256/1/0",
                     dc, dk, dd, order_err);
        end
        vectors++;
        if (cum_log[0] !== 20'd10 || cum_log[127] !== 20'd1280 || cum_log[255] !== 20'd2560 ||
            disp_log[200] !== 20'd10) begin
            errors++;
            $display("FAIL thr_cum: c0=%0d c127=%0d c255=%0d d200=%0d required 10/1280/2560/10",
                     cum_log[0], cum_log[127], cum_log[255], disp_log[200]);
        end
        vectors++;
        if (thresh_bin !== 8'd127 || thresh_valid !== 1'b1) begin
            errors++;
            $display("FAIL thr_bin: bin=%0d valid=%b required 127/1", thresh_bin, thresh_valid);
        end
        vectors++;
        if (tmp_ram[7] !== 20'd0) begin
            errors++;
            $display("FAIL thr_temp_cleared: bin7=%0d required 0", tmp_ram[7]);
        end
    endtask

    task automatic test_freeze;
        logic acc; int dc, dk, dd;
        load_bins(20'd10, 20'd10, 20'd10);
        run_frame(50, 20'd5000, 1'b1, acc, dc, dk, dd);
        freeze = 1'b0;
        vectors++;
        if (dc != 0 || dk != 256 || dd != 1) begin
            errors++;
            $display("FAIL frz_counts: copy=%0d clr=%0d done=%0d required 0/256/1", dc, dk, dd);
        end
        vectors++;
        if (thresh_bin !== 8'd127 || thresh_valid !== 1'b1) begin
            errors++;
            $display("FAIL frz_hold: bin=%0d valid=%b required 127/1", thresh_bin, thresh_valid);
        end
    endtask

    task automatic test_no_cross;
        logic acc; int dc, dk, dd;
        load_bins(20'd10, 20'd10, 20'd10);
        run_frame(30, 20'd5000, 1'b0, acc, dc, dk, dd);
        vectors++;
        if (thresh_bin !== 8'd255 || thresh_valid !== 1'b0 || cum_log[255] !== 20'd2560) begin
            errors++;
            $display("FAIL nocross: bin=%0d valid=%b c255=%0d required 255/0/2560",
                     thresh_bin, thresh_valid, cum_log[255]);
        end
    endtask

    task automatic test_skip;
        int c0, s0, n0, n;
        c0 = copy_cnt; s0 = skip_cnt; n0 = done_cnt;
        level = 20'd1279;
        @(posedge clk); #1 fval = 1'b1;
        repeat (20) @(posedge clk);
        #1 fval = 1'b0;
        n = 0;
        while (phase !== 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (phase !== 3'd3) begin
            errors++;
            $display("FAIL skip_reach_copy: phase=%0d required 3", phase);
        end
        @(posedge clk); #1 fval = 1'b1;
        wait_done(n0, 1200);
        repeat (20) @(negedge clk);
        vectors++;
        if (skip_cnt - s0 != 1 || done_cnt - n0 != 1 || copy_cnt - c0 != 256) begin
            errors++;
            $display("FAIL skip_counts: skip=%0d done=%0d copy=%0d required 1/1/256",
                     skip_cnt - s0, done_cnt - n0, copy_cnt - c0);
        end
        vectors++;
        if (phase !== 3'd0 || accum_en !== 1'b0) begin
            errors++;
            $display("FAIL skip_idle_hold: phase=%0d accum=%b required 0/0", phase, accum_en);
        end
        @(posedge clk); #1 fval = 1'b0;
        repeat (2) @(posedge clk);
        #1 fval = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (phase !== 3'd1 || accum_en !== 1'b1) begin
            errors++;
            $display("FAIL skip_fresh_start: phase=%0d accum=%b required 1/1", phase, accum_en);
        end
        n0 = done_cnt;
        @(posedge clk); #1 fval = 1'b0;
        wait_done(n0, 1200);
    endtask

    task automatic test_overflow;
        logic acc; int dc, dk, dd;
        logic [CNT_W-1:0] exp1;
`ifdef HISTO_SEQ_CUM_SAT_EN
        exp1 = 20'hFFFFF;
`else
        exp1 = 20'd4;
`endif
        load_bins(20'hFFFFF, 20'd5, 20'd0);
        run_frame(10, 20'd5000, 1'b0, acc, dc, dk, dd);
        vectors++;
        if (cum_log[0] !== 20'hFFFFF || cum_log[1] !== exp1 || cum_log[255] !== exp1 ||
            disp_log[1] !== 20'd5) begin
            errors++;
            $display("FAIL ovf_cum: c0=%0h c1=%0h c255=%0h d1=%0d required fffff/%0h/%0h/5",
                     cum_log[0], cum_log[1], cum_log[255], disp_log[1], exp1, exp1);
        end
        vectors++;
        if (thresh_bin !== 8'd0 || thresh_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_first_cross: bin=%0d valid=%b required 0/1", thresh_bin, thresh_valid);
        end
    endtask

    initial begin
        test_reset;
        test_threshold;
        test_freeze;
        test_no_cross;
        test_skip;
        test_overflow;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
